pb_event_capture: RTL and testbench

//  Input-side counterpart of the LED PIO. Conditions the board pushbuttons (user_pb) for the q_sys CPU.
//  Per button: a 2-FF synchronizer, a debounce filter and press-edge capture.

---
 rtl/pb_event_capture_pkg.sv | 19 +
 rtl/pb_debounce.sv | 52 +++++
 rtl/pb_event_capture.sv | 91 +++++++++
 tb/tb_pb_event_capture.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_event_capture_pkg.sv
// Shared definitions for the pushbutton event-capture block: register map,
// press-counter geometry and the saturating increment used by the counters.
package pb_event_capture_pkg;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_MASK   = 2'd1,
    REG_EDGE   = 2'd2,
    REG_COUNT  = 2'd3
  } reg_addr_e;

  localparam int                 COUNT_W   = 8;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 8'd255;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// One pushbutton: 2-FF synchronizer, polarity normalisation, debounce counter
// and a one-cycle pulse when the debounced state goes released -> pressed.
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PB_ACTIVE_LOW   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic stable,
  output logic press_pulse
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] TERM     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RELEASED = (PB_ACTIVE_LOW != 0);

  logic             sync1;
  logic             sync2;
  logic             p;
  logic [CNT_W-1:0] cnt;

  assign p = (PB_ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Sync flops come out of reset at the released pin level so that leaving
  // reset never looks like a press.
  // NOTE: all state updates use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= RELEASED;
      sync2       <= RELEASED;
      cnt         <= '0;
      stable      <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= pin;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      if (p == stable) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        stable      <= p;
        cnt         <= '0;
        press_pulse <= p;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pb_event_capture.sv
// Pushbutton event capture: per-button debounce, sticky press flags, press
// counters, level irq and a 4-word Avalon-MM slave with read latency 1.
module pb_event_capture
  import pb_event_capture_pkg::*;
#(
  parameter int NUM_PB          = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PB_ACTIVE_LOW   = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [NUM_PB-1:0] pb_in,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq,
  output logic [NUM_PB-1:0] pb_pressed
);

  // The COUNT word holds four bytes; buttons beyond the fourth are not counted.
  localparam int NUM_CNT = (NUM_PB < 4) ? NUM_PB : 4;

  logic [NUM_PB-1:0]  press;
  logic [NUM_PB-1:0]  mask_q;
  logic [NUM_PB-1:0]  edge_q;
  logic [COUNT_W-1:0] press_count [NUM_CNT];
  logic [31:0]        rd_data;
  reg_addr_e          addr;
  logic               wr_mask;
  logic               wr_edge;
  logic               wr_count;
  logic               unused_wdata;

  for (genvar g = 0; g < NUM_PB; g++) begin : g_pb
    pb_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .PB_ACTIVE_LOW   (PB_ACTIVE_LOW)
    ) u_debounce (
      .clk         (clk_clk),
      .rst_n       (reset_reset_n),
      .pin         (pb_in[g]),
      .stable      (pb_pressed[g]),
      .press_pulse (press[g])
    );
  end

  assign addr         = reg_addr_e'(avs_address);
  assign wr_mask      = avs_write && (addr == REG_MASK);
  assign wr_edge      = avs_write && (addr == REG_EDGE);
  assign wr_count     = avs_write && (addr == REG_COUNT);
  assign unused_wdata = &{1'b0, avs_writedata[31:NUM_PB]};

  // A press in the same cycle as a W1C or a count clear wins over the clear.
  // NOTE: the small counter array is explicitly reset; it is a register file,
  // not a RAM, and software expects zero counts after reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mask_q       <= '0;
      edge_q       <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
      for (int i = 0; i < NUM_CNT; i++) press_count[i] <= '0;
    end else begin
      if (wr_mask) mask_q <= avs_writedata[NUM_PB-1:0];
      edge_q <= (edge_q & ~(wr_edge ? avs_writedata[NUM_PB-1:0] : '0)) | press;
      irq    <= |(edge_q & mask_q);
      for (int i = 0; i < NUM_CNT; i++) begin
        if (press[i])      press_count[i] <= wr_count ? COUNT_W'(1) : sat_inc(press_count[i]);
        else if (wr_count) press_count[i] <= '0;
      end
      if (avs_read) avs_readdata <= rd_data;
    end
  end

  // NOTE: rd_data gets a full default before the case so no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (addr)
      REG_STATUS: rd_data[NUM_PB-1:0] = pb_pressed;
      REG_MASK:   rd_data[NUM_PB-1:0] = mask_q;
      REG_EDGE:   rd_data[NUM_PB-1:0] = edge_q;
      REG_COUNT: begin
        for (int i = 0; i < NUM_CNT; i++) rd_data[i*COUNT_W +: COUNT_W] = press_count[i];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pb_event_capture.sv
// Self-checking bench for pb_event_capture: a window-based reference model of
// debounce, press flags, counters and irq, exercised by directed and random stimulus.
module tb_pb_event_capture;

  localparam int D   = 16;
  localparam int LAT = D + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pb_in = 2'b11;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [1:0]  pb_pressed;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  pb_event_capture #(
    .NUM_PB          (2),
    .DEBOUNCE_CYCLES (D),
    .PB_ACTIVE_LOW   (1)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .pb_in         (pb_in),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .pb_pressed    (pb_pressed)
  );

  // Reference model: a button's accepted state flips once the last D synced
  // samples (pin delayed by two clocks) all disagree with it.
  logic [D+1:0] m_hist [2];
  logic [1:0]   m_stable, m_pulse, m_edge, m_mask;
  logic         m_irq;
  int           m_cnt [2];

  always @(posedge clk or negedge rst_n) begin
    logic [D+1:0] h;
    logic         flip;
    if (!rst_n) begin
      m_stable <= '0; m_pulse <= '0; m_edge <= '0; m_mask <= '0; m_irq <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_hist[i] <= '0;
        m_cnt[i]  <= 0;
      end
    end else begin
      m_irq <= |(m_edge & m_mask);
      if (avs_write && avs_address == 2'd1) m_mask <= avs_writedata[1:0];
      m_edge <= (m_edge & ~((avs_write && avs_address == 2'd2) ? avs_writedata[1:0] : 2'b00)) | m_pulse;
      for (int i = 0; i < 2; i++) begin
        h    = {m_hist[i][D:0], (pb_in[i] == 1'b0)};
        flip = (h[D+1:2] == {D{~m_stable[i]}});
        m_hist[i] <= h;
        if (flip) m_stable[i] <= ~m_stable[i];
        m_pulse[i] <= flip && !m_stable[i];
        if (avs_write && avs_address == 2'd3) m_cnt[i] <= m_pulse[i] ? 1 : 0;
        else if (m_pulse[i]) m_cnt[i] <= (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
      end
    end
  end

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, m_stable};
      2'd1:    return {30'd0, m_mask};
      2'd2:    return {30'd0, m_edge};
      default: return {16'd0, 8'(m_cnt[1]), 8'(m_cnt[0])};
    endcase
  endfunction

  always @(negedge clk) begin
    n_checks++;
    if (pb_pressed !== m_stable) begin
      n_fail++;
      $display("FAIL pb_pressed @%0t: got %b expected %b", $time, pb_pressed, m_stable);
    end
    n_checks++;
    if (irq !== m_irq) begin
      n_fail++;
      $display("FAIL irq @%0t: got %b expected %b", $time, irq, m_irq);
    end
  end

  // Bus tasks are entered at a falling edge and return at a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(posedge clk);
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input string name, output logic [31:0] got);
    logic [31:0] exp;
    exp = m_reg(a);
    avs_read = 1'b1; avs_address = a;
    @(posedge clk);
    @(negedge clk);
    avs_read = 1'b0;
    got = avs_readdata;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: read %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_rise(input int b, input int limit, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < limit && !ok) begin
      @(negedge clk);
      cyc++;
      if (pb_pressed[b] === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] got;
    rst_n = 1'b0; pb_in = 2'b11;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({avs_readdata, irq, pb_pressed} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: readdata %h irq %b pressed %b, all must be 0", avs_readdata, irq, pb_pressed);
    end
    rst_n = 1'b1;
    bus_read(2'd0, "reset_status", got);
    bus_read(2'd2, "reset_edge", got);
    bus_read(2'd3, "reset_count", got);
    repeat (100) @(negedge clk);
    bus_read(2'd2, "idle_edge", got);
    n_checks++;
    if (got !== 32'd0) begin n_fail++; $display("FAIL idle_edge_zero: got %h expected 0", got); end
    bus_read(2'd3, "idle_count", got);
    n_checks++;
    if (got !== 32'd0) begin n_fail++; $display("FAIL idle_count_zero: got %h expected 0", got); end
  endtask

  task automatic test_press_latency;
    logic [31:0] got;
    int cyc;
    bit ok;
    pb_in[0] = 1'b0;
    wait_rise(0, 40, cyc, ok);
    n_checks++;
    if (!ok || cyc != LAT) begin
      n_fail++;
      $display("FAIL press_latency: rose after %0d cycles (seen=%0d) expected %0d", cyc, ok, LAT);
    end
    repeat (3) @(negedge clk);
    bus_read(2'd2, "press_edge", got);
    n_checks++;
    if (got !== 32'h1) begin n_fail++; $display("FAIL press_edge_value: got %h expected 1", got); end
    bus_read(2'd3, "press_count", got);
    n_checks++;
    if (got !== 32'h1) begin n_fail++; $display("FAIL press_count_value: got %h expected 1", got); end
  endtask

  task automatic test_bounce;
    logic [31:0] got;
    for (int i = 0; i < 20; i++) begin
      pb_in[1] = ~pb_in[1];
      repeat (10) @(negedge clk);
    end
    bus_read(2'd3, "bounce_count", got);
    n_checks++;
    if (got !== 32'h1) begin n_fail++; $display("FAIL bounce_no_event: got %h expected 1", got); end
    pb_in[1] = 1'b0;
    repeat (30) @(negedge clk);
    bus_read(2'd3, "settled_count", got);
    n_checks++;
    if (got !== 32'h0101) begin n_fail++; $display("FAIL settled_one_event: got %h expected 0101", got); end
  endtask

  task automatic test_irq;
    logic [31:0] got;
    int cyc;
    bit ok;
    bus_write(2'd2, 32'h3);
    bus_write(2'd1, 32'h2);
    pb_in[1] = 1'b1;
    repeat (25) @(negedge clk);
    pb_in[1] = 1'b0;
    wait_rise(1, 40, cyc, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL irq_press_seen: button 1 never pressed"); end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b expected 0", irq); end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_assert: got %b expected 1", irq); end
    // Second press: clear EDGE[1] in the very cycle its press pulse is high.
    pb_in[1] = 1'b1;
    repeat (25) @(negedge clk);
    pb_in[1] = 1'b0;
    wait_rise(1, 40, cyc, ok);
    bus_write(2'd2, 32'h2);
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b expected 1", irq); end
    bus_read(2'd2, "edge_set_wins", got);
    n_checks++;
    if (got[1] !== 1'b1) begin n_fail++; $display("FAIL edge_set_wins_bit: got %b expected 1", got[1]); end
    bus_write(2'd2, 32'h2);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold_after_clear: got %b expected 1", irq); end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_deassert: got %b expected 0", irq); end
  endtask

  task automatic test_saturation;
    logic [31:0] got;
    for (int i = 0; i < 260; i++) begin
      pb_in[0] = 1'b1;
      repeat ($urandom_range(LAT, LAT + 6)) @(negedge clk);
      pb_in[0] = 1'b0;
      repeat ($urandom_range(LAT, LAT + 6)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    bus_read(2'd3, "sat_count", got);
    n_checks++;
    if (got[7:0] !== 8'hFF) begin n_fail++; $display("FAIL sat_byte0: got %h expected ff", got[7:0]); end
    bus_write(2'd3, $urandom);
    bus_read(2'd3, "cleared_count", got);
    n_checks++;
    if (got !== 32'd0) begin n_fail++; $display("FAIL count_clear: got %h expected 0", got); end
  endtask

  task automatic test_random;
    logic [31:0] got;
    for (int i = 0; i < 60; i++) begin
      pb_in = 2'($urandom);
      repeat ($urandom_range(1, 30)) @(negedge clk);
      case ($urandom_range(0, 4))
        0:       bus_write(2'd1, $urandom);
        1:       bus_write(2'd2, $urandom);
        2:       bus_write(2'($urandom), $urandom);
        default: ;
      endcase
      bus_read(2'($urandom), "random_read", got);
    end
  endtask

  task automatic test_reset_mid_debounce;
    logic [31:0] got;
    int cyc;
    bit ok;
    bus_write(2'd1, 32'h3);
    pb_in = 2'b01;
    repeat (25) @(negedge clk);
    bus_read(2'd0, "pre_reset_status", got);
    pb_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({avs_readdata, irq, pb_pressed} !== 35'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: readdata %h irq %b pressed %b, all must be 0", avs_readdata, irq, pb_pressed);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_rise(0, 40, cyc, ok);
    n_checks++;
    if (!ok || cyc != LAT) begin
      n_fail++;
      $display("FAIL post_reset_latency: rose after %0d cycles (seen=%0d) expected %0d", cyc, ok, LAT);
    end
    repeat (3) @(negedge clk);
    bus_read(2'd3, "post_reset_count", got);
    n_checks++;
    if (got[7:0] !== 8'd1) begin n_fail++; $display("FAIL post_reset_one_event: got %h expected 01", got[7:0]); end
  endtask

  initial begin
    test_reset;
    test_press_latency;
    test_bounce;
    test_irq;
    test_saturation;
    test_random;
    test_reset_mid_debounce;
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
